image_format_frame: RTL and testbench
=====================================

IMAGE_FORMAT_FRAME -- requirements
Module: image_format_frame

Interface
REQ-001 SHALL have parameter REPEAT_NUM, default 5, meaning frames sent per start (1..15).
REQ-002 SHALL have parameter GAP_CYCLES, default 25_000_000, meaning idle cycles before each frame (>=1).
REQ-003 SHALL have parameter END_HOLD, default 2500, meaning cycles between the last tx_done and the done pulse.
REQ-004 SHALL have parameter DEV_ADDR, default 8'h00, meaning the device address byte.
REQ-005 SHALL have port clk, input, 1, the single clock.
REQ-006 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-007 SHALL have port start, input, 1, one-cycle request to begin a sequence.
REQ-008 SHALL have port cfg_format, input, 8, format code (04 RGB565, 05 RGB888).
REQ-009 SHALL have ports cfg_h_pixel and cfg_v_pixel, input, 16 each, image width and height.
REQ-010 SHALL have port tx_byte_req, input, 1, UDP core consumed current byte, advance.
REQ-011 SHALL have port tx_done, input, 1, UDP core finished current packet.
REQ-012 SHALL have port tx_start, output, 1, one-cycle packet-send request.
REQ-013 SHALL have port tx_data, output, 8, current frame byte.
REQ-014 SHALL have port tx_num, output, 16, constant 17 (payload bytes).
REQ-015 SHALL have ports busy and done, output, 1 each: sequence active; one-cycle completion pulse.

Function
REQ-016 Frame bytes 0..16 SHALL be 53 5A 48 59, DEV_ADDR, 11 00 00 00, 01, format, H low, H high, V low, V high, CRC low, CRC high.
REQ-017 start SHALL be accepted only in IDLE; cfg_* latched on the accept cycle; start while busy ignored.
REQ-018 States SHALL be IDLE, GAP, CRC, SEND, CYCLE, HOLD; busy=1 in all except IDLE.
REQ-019 GAP SHALL count GAP_CYCLES cycles, then pulse tx_start for one cycle and go to CRC, or to SEND when CRC is compiled out.
REQ-020 CRC SHALL process bytes 0..14 one per cycle (15 cycles), then go to SEND.
REQ-021 In SEND, tx_data SHALL equal byte[idx]; each tx_byte_req increments idx, visible next cycle; idx saturates at 16.
REQ-022 tx_done SHALL be honoured only in SEND with idx==16; otherwise it SHALL be ignored.
REQ-023 CYCLE SHALL increment the 4-bit frame counter, go to GAP if count<REPEAT_NUM, else to HOLD; idx cleared.
REQ-024 HOLD SHALL count END_HOLD cycles, pulse done once, then return to IDLE; a new start is accepted the following cycle.
REQ-025 tx_data SHALL be 8'h00 outside SEND.
REQ-026 tx_start SHALL not assert while the packet in progress has not returned tx_done.

Reset
REQ-027 rst SHALL force IDLE, clear all counters, idx, CRC register and latched config; tx_start=0, tx_data=0, busy=0, done=0.
REQ-028 rst asserted mid-sequence SHALL abort without a done pulse; first post-reset start begins from frame 0.

Configuration
REQ-029 Macro IMAGE_FORMAT_CRC_EN defined: CRC-16/MODBUS (reflected poly 0xA001, init 0xFFFF) over bytes 0..14, transmitted low byte first.
REQ-030 Macro IMAGE_FORMAT_CRC_EN undefined: CRC state, CRC register and crc16_modbus_byte SHALL be absent; bytes 15..16 SHALL be 7C 0B.

Structure
REQ-031 Package image_format_pkg SHALL hold header bytes, CMD 8'h01, frame length 17, data-length field, state encoding, format codes.
REQ-032 Sub-module crc16_modbus_byte SHALL hold the one-byte combinational CRC update; instantiated only under IMAGE_FORMAT_CRC_EN.

Verification (GAP_CYCLES=8, END_HOLD=4, REPEAT_NUM=2)
REQ-033 start, 1280x720, format 04 -> tx_start 8 cycles later; bytes 53 5A 48 59 00 11 00 00 00 01 04 00 05 D0 02 plus CRC equal to bench MODBUS model.
REQ-034 Two full frames -> exactly 2 tx_start pulses, done one cycle after 4 HOLD cycles, busy falls with it.
REQ-035 start during SEND with different cfg -> ignored; frame bytes unchanged.
REQ-036 tx_done injected at idx=5 -> ignored; frame completes normally on the later tx_done.
REQ-037 rst during second GAP -> all outputs 0 at once; a new start completes a full 2-frame sequence.
REQ-038 Build without IMAGE_FORMAT_CRC_EN -> bytes 15..16 = 7C 0B, tx_start to SEND with no 15-cycle gap.

Source files
------------

// File: rtl/image_format_pkg.sv
// Shared constants, state encoding and frame byte mux for the image-format frame sender.
// IMAGE_FORMAT_CRC_EN selects whether the CRC state exists.
package image_format_pkg;

  localparam logic [7:0]  Hdr0         = 8'h53;
  localparam logic [7:0]  Hdr1         = 8'h5A;
  localparam logic [7:0]  Hdr2         = 8'h48;
  localparam logic [7:0]  Hdr3         = 8'h59;
  localparam logic [7:0]  CmdByte      = 8'h01;
  localparam int unsigned FrameLen     = 17;
  localparam logic [31:0] DataLenField = 32'h0000_0011;
  localparam logic [7:0]  FmtRgb565    = 8'h04;
  localparam logic [7:0]  FmtRgb888    = 8'h05;
  localparam logic [15:0] CrcInit      = 16'hFFFF;
  // Bytes 15..16 when the CRC engine is compiled out (sent as 7C 0B).
  localparam logic [15:0] CrcFixed     = 16'h0B7C;

`ifdef IMAGE_FORMAT_CRC_EN
  typedef enum logic [2:0] {StIdle, StGap, StCrc, StSend, StCycle, StHold} state_e;
`else
  typedef enum logic [2:0] {StIdle, StGap, StSend, StCycle, StHold} state_e;
`endif

  function automatic logic [7:0] frame_byte(input logic [4:0]  idx,
                                            input logic [7:0]  dev,
                                            input logic [7:0]  fmt,
                                            input logic [15:0] h,
                                            input logic [15:0] v,
                                            input logic [15:0] crc);
    logic [7:0] b;
    case (idx)
      5'd0:    b = Hdr0;
      5'd1:    b = Hdr1;
      5'd2:    b = Hdr2;
      5'd3:    b = Hdr3;
      5'd4:    b = dev;
      5'd5:    b = DataLenField[7:0];
      5'd6:    b = DataLenField[15:8];
      5'd7:    b = DataLenField[23:16];
      5'd8:    b = DataLenField[31:24];
      5'd9:    b = CmdByte;
      5'd10:   b = fmt;
      5'd11:   b = h[7:0];
      5'd12:   b = h[15:8];
      5'd13:   b = v[7:0];
      5'd14:   b = v[15:8];
      5'd15:   b = crc[7:0];
      5'd16:   b = crc[15:8];
      default: b = 8'h00;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/crc16_modbus_byte.sv
// One-byte combinational CRC-16/MODBUS update (reflected polynomial 0xA001).
module crc16_modbus_byte (
  input  logic [15:0] crc_i,
  input  logic [7:0]  data_i,
  output logic [15:0] crc_o
);

  always_comb begin
    crc_o = crc_i ^ {8'h00, data_i};
    for (int i = 0; i < 8; i++) begin
      crc_o = crc_o[0] ? ((crc_o >> 1) ^ 16'hA001) : (crc_o >> 1);
    end
  end

endmodule

// File: rtl/image_format_frame.sv
// Sends REPEAT_NUM 17-byte image-format frames per start, spaced by GAP_CYCLES idle cycles.
// Define IMAGE_FORMAT_CRC_EN to compute a MODBUS CRC over bytes 0..14 instead of a fixed trailer.
module image_format_frame
  import image_format_pkg::*;
#(
  parameter int unsigned REPEAT_NUM = 5,
  parameter int unsigned GAP_CYCLES = 25_000_000,
  parameter int unsigned END_HOLD   = 2500,
  parameter logic [7:0]  DEV_ADDR   = 8'h00
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  cfg_format,
  input  logic [15:0] cfg_h_pixel,
  input  logic [15:0] cfg_v_pixel,
  input  logic        tx_byte_req,
  input  logic        tx_done,
  output logic        tx_start,
  output logic [7:0]  tx_data,
  output logic [15:0] tx_num,
  output logic        busy,
  output logic        done
);

  localparam int unsigned GapW    = $clog2(GAP_CYCLES + 1);
  localparam int unsigned HoldMax = (END_HOLD > 0) ? END_HOLD : 1;
  localparam int unsigned HoldW   = $clog2(HoldMax + 1);
  localparam logic [GapW-1:0]  GapLast  = GapW'(GAP_CYCLES - 1);
  localparam logic [HoldW-1:0] HoldLast = HoldW'(HoldMax - 1);
  localparam logic [4:0]       IdxLast  = 5'(FrameLen - 1);

  state_e            state_q;
  logic [GapW-1:0]   gap_cnt_q;
  logic [HoldW-1:0]  hold_cnt_q;
  logic [3:0]        frame_cnt_q;
  logic [4:0]        frame_cnt_d;
  logic [4:0]        idx_q;
  logic [7:0]        fmt_q;
  logic [15:0]       h_q;
  logic [15:0]       v_q;
  logic              tx_start_q;
  logic              done_q;
  logic [15:0]       crc_val;
  logic [7:0]        cur_byte;

`ifdef IMAGE_FORMAT_CRC_EN
  localparam logic [4:0] CrcLast = 5'(FrameLen - 3);
  logic [15:0] crc_q;
  logic [15:0] crc_next;

  assign crc_val = crc_q;

  crc16_modbus_byte u_crc (
    .crc_i  (crc_q),
    .data_i (cur_byte),
    .crc_o  (crc_next)
  );
`else
  assign crc_val = CrcFixed;
`endif

  always_comb begin
    cur_byte    = frame_byte(idx_q, DEV_ADDR, fmt_q, h_q, v_q, crc_val);
    frame_cnt_d = {1'b0, frame_cnt_q} + 5'd1;
    tx_data     = (state_q == StSend) ? cur_byte : 8'h00;
  end

  assign tx_start = tx_start_q;
  assign done     = done_q;
  assign busy     = (state_q != StIdle);
  assign tx_num   = 16'(FrameLen);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      gap_cnt_q   <= '0;
      hold_cnt_q  <= '0;
      frame_cnt_q <= '0;
      idx_q       <= '0;
      fmt_q       <= '0;
      h_q         <= '0;
      v_q         <= '0;
      tx_start_q  <= 1'b0;
      done_q      <= 1'b0;
`ifdef IMAGE_FORMAT_CRC_EN
      crc_q       <= '0;
`endif
    end else begin
      tx_start_q <= 1'b0;
      done_q     <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            fmt_q       <= cfg_format;
            h_q         <= cfg_h_pixel;
            v_q         <= cfg_v_pixel;
            frame_cnt_q <= '0;
            gap_cnt_q   <= '0;
            idx_q       <= '0;
            state_q     <= StGap;
          end
        end
        StGap: begin
          if (gap_cnt_q == GapLast) begin
            gap_cnt_q  <= '0;
            idx_q      <= '0;
            tx_start_q <= 1'b1;
`ifdef IMAGE_FORMAT_CRC_EN
            crc_q      <= CrcInit;
            state_q    <= StCrc;
`else
            state_q    <= StSend;
`endif
          end else begin
            gap_cnt_q <= gap_cnt_q + 1'b1;
          end
        end
`ifdef IMAGE_FORMAT_CRC_EN
        // idx walks bytes 0..14 here, then restarts at 0 for transmission.
        StCrc: begin
          crc_q <= crc_next;
          if (idx_q == CrcLast) begin
            idx_q   <= '0;
            state_q <= StSend;
          end else begin
            idx_q <= idx_q + 5'd1;
          end
        end
`endif
        StSend: begin
          if (tx_done && (idx_q == IdxLast)) begin
            state_q <= StCycle;
          end else if (tx_byte_req && (idx_q != IdxLast)) begin
            idx_q <= idx_q + 5'd1;
          end
        end
        StCycle: begin
          frame_cnt_q <= frame_cnt_d[3:0];
          idx_q       <= '0;
          if (frame_cnt_d < 5'(REPEAT_NUM)) begin
            gap_cnt_q <= '0;
            state_q   <= StGap;
          end else begin
            hold_cnt_q <= '0;
            state_q    <= StHold;
          end
        end
        StHold: begin
          if (hold_cnt_q == HoldLast) begin
            done_q  <= 1'b1;
            state_q <= StIdle;
          end else begin
            hold_cnt_q <= hold_cnt_q + 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_image_format_frame.sv
// Directed, table-driven bench for image_format_frame (GAP_CYCLES=8, END_HOLD=4, REPEAT_NUM=2).
module tb_image_format_frame;

  localparam int unsigned Gap  = 8;
  localparam int unsigned Hold = 4;
  localparam int unsigned Rep  = 2;
`ifdef IMAGE_FORMAT_CRC_EN
  localparam int unsigned ExpLat = 15;
`else
  localparam int unsigned ExpLat = 0;
`endif

  typedef struct packed {
    logic [7:0]  fmt;
    logic [15:0] h;
    logic [15:0] v;
    logic [39:0] exp_mid;  // expected bytes 10..14, byte 10 in the top bits
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  cfg_format;
  logic [15:0] cfg_h_pixel;
  logic [15:0] cfg_v_pixel;
  logic        tx_byte_req;
  logic        tx_done;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic [15:0] tx_num;
  logic        busy;
  logic        done;

  int checks   = 0;
  int failures = 0;
  int start_seen = 0;
  int done_seen  = 0;

  vec_t       vecs [4];
  logic [7:0] exp_b [17];
  logic [7:0] hdr [10];

  image_format_frame #(
    .REPEAT_NUM (Rep),
    .GAP_CYCLES (Gap),
    .END_HOLD   (Hold)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .cfg_format  (cfg_format),
    .cfg_h_pixel (cfg_h_pixel),
    .cfg_v_pixel (cfg_v_pixel),
    .tx_byte_req (tx_byte_req),
    .tx_done     (tx_done),
    .tx_start    (tx_start),
    .tx_data     (tx_data),
    .tx_num      (tx_num),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (tx_start) start_seen++;
    if (done) done_seen++;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] crc_model();
    logic [15:0] c;
    c = 16'hFFFF;
    for (int i = 0; i < 15; i++) begin
      c = c ^ {8'h00, exp_b[i]};
      for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 16'hA001) : (c >> 1);
    end
    return c;
  endfunction

  task automatic build_exp(input int vi);
    logic [15:0] c;
    for (int i = 0; i < 10; i++) exp_b[i] = hdr[i];
    for (int k = 0; k < 5; k++) exp_b[10+k] = vecs[vi].exp_mid[39-8*k -: 8];
    c = crc_model();
`ifdef IMAGE_FORMAT_CRC_EN
    exp_b[15] = c[7:0];
    exp_b[16] = c[15:8];
`else
    exp_b[15] = 8'h7C;
    exp_b[16] = 8'h0B;
`endif
  endtask

  // Counts negedges until tx_start is seen, starting from n0.
  task automatic wait_tx_start(input int n0, input int exp_n, input string name);
    int n;
    n = n0;
    while (!tx_start && n < 200) begin
      @(negedge clk);
      n++;
    end
    check(name, n, exp_n);
  endtask

  // Entered on the tx_start cycle; returns one cycle after tx_done was driven.
  // mode 1 injects an early tx_done; mode 2 issues a start with other cfg mid-frame.
  task automatic send_frame(input int mode);
    int n;
    n = 0;
    while (tx_data !== 8'h53 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("send_latency", n, ExpLat);
    for (int i = 0; i < 17; i++) begin
      check($sformatf("byte%0d", i), tx_data, exp_b[i]);
      check("busy_send", busy, 1'b1);
      tx_byte_req = 1'b1;
      if (mode == 1 && i == 5) tx_done = 1'b1;
      if (mode == 2 && i == 8) begin
        start       = 1'b1;
        cfg_format  = 8'h05;
        cfg_h_pixel = 16'h0BAD;
        cfg_v_pixel = 16'h0BEE;
      end
      @(negedge clk);
      tx_byte_req = 1'b0;
      tx_done     = 1'b0;
      start       = 1'b0;
    end
    check("idx_saturate", tx_data, exp_b[16]);
    tx_done = 1'b1;
    @(negedge clk);
    tx_done = 1'b0;
  endtask

  task automatic run_sequence(input int vi, input int mode);
    int n;
    int s0;
    s0 = start_seen;
    build_exp(vi);
    cfg_format  = vecs[vi].fmt;
    cfg_h_pixel = vecs[vi].h;
    cfg_v_pixel = vecs[vi].v;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("busy_after_start", busy, 1'b1);
    wait_tx_start(1, Gap + 1, "first_gap");
    send_frame(mode);
    wait_tx_start(1, Gap + 2, "second_gap");
    send_frame(0);
    n = 1;
    while (!done && n < 100) begin
      check("no_early_done_busy", busy, 1'b1);
      @(negedge clk);
      n++;
    end
    check("done_delay", n, Hold + 2);
    check("busy_with_done", busy, 1'b0);
    @(negedge clk);
    check("done_pulse_width", done, 1'b0);
    check("tx_start_pulses", start_seen - s0, Rep);
  endtask

  initial begin
    hdr = '{8'h53, 8'h5A, 8'h48, 8'h59, 8'h00, 8'h11, 8'h00, 8'h00, 8'h00, 8'h01};
    vecs[0] = '{8'h04, 16'd1280,  16'd720,    {8'h04, 8'h00, 8'h05, 8'hD0, 8'h02}};
    vecs[1] = '{8'h05, 16'd640,   16'd480,    {8'h05, 8'h80, 8'h02, 8'hE0, 8'h01}};
    vecs[2] = '{8'h04, 16'hFFFF,  16'h0001,   {8'h04, 8'hFF, 8'hFF, 8'h01, 8'h00}};
    vecs[3] = '{8'h05, 16'h0001,  16'h1234,   {8'h05, 8'h01, 8'h00, 8'h34, 8'h12}};

    rst = 1'b1;
    start = 1'b0;
    cfg_format = '0;
    cfg_h_pixel = '0;
    cfg_v_pixel = '0;
    tx_byte_req = 1'b0;
    tx_done = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_tx_start", tx_start, 1'b0);
    check("rst_tx_data", tx_data, 8'h00);
    check("tx_num", tx_num, 16'd17);
    rst = 1'b0;
    @(negedge clk);
    check("idle_busy", busy, 1'b0);

    // Start ignored before reset-free idle? No: stray tx_done in IDLE must do nothing.
    tx_done = 1'b1;
    @(negedge clk);
    tx_done = 1'b0;
    check("idle_tx_done_ignored", busy, 1'b0);

    for (int vi = 0; vi < 4; vi++) run_sequence(vi, (vi == 1) ? 1 : (vi == 2) ? 2 : 0);

    // Abort during the second gap, then a clean sequence must run from frame 0.
    build_exp(0);
    cfg_format  = vecs[0].fmt;
    cfg_h_pixel = vecs[0].h;
    cfg_v_pixel = vecs[0].v;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_tx_start(1, Gap + 1, "rst_seq_gap");
    send_frame(0);
    repeat (3) @(negedge clk);
    check("pre_rst_busy", busy, 1'b1);
    begin
      int d0;
      d0 = done_seen;
      #2 rst = 1'b1;
      #1;
      check("abort_busy", busy, 1'b0);
      check("abort_done", done, 1'b0);
      check("abort_tx_start", tx_start, 1'b0);
      check("abort_tx_data", tx_data, 8'h00);
      @(negedge clk);
      rst = 1'b0;
      repeat (Gap + 4) @(negedge clk);
      check("abort_stays_idle", busy, 1'b0);
      check("abort_no_done", done_seen - d0, 0);
    end
    run_sequence(1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
